math_op_sched: RTL

- Shared, sequenced square/cube/factorial engine for NREQ requesters.
- A round-robin arbiter grants one request at a time. An FSM then evaluates the result iteratively with a single 8-bit x 4-bit multiplier, one multiply per cycle.
- The result is returned on a valid/ready response channel, tagged with the requester id.
- Sits between control-path clients and replaces per-client combinational power/factorial logic.

---
 rtl/math_op_pkg.sv | 18 +
 rtl/math_op_sched_rr_arbiter.sv | 30 +++
 rtl/math_op_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/math_op_pkg.sv
// Shared types and constants for the sequenced square/cube/factorial engine.
package math_op_pkg;

    // Default operand and result widths
    localparam int unsigned DEF_NW = 4;
    localparam int unsigned DEF_OW = 8;

    localparam logic [2:0] OP_SQUARE = 3'd0;
    localparam logic [2:0] OP_CUBE   = 3'd1;
    localparam logic [2:0] OP_FACT   = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/math_op_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    logic           w_found;
    logic [IDW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((32'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/math_op_sched.sv
// Shared square/cube/factorial engine: one arbitrated request at a time,
// evaluated with a single OW x NW multiply per cycle, answered on a valid/ready channel.
module math_op_sched
    import math_op_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned NW   = DEF_NW,
    parameter int unsigned OW   = DEF_OW,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_opcode,
    input  logic [NW*NREQ-1:0] req_n,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OW-1:0]     rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_err,
    output logic              busy
);

    state_e         r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [OW-1:0]  r_acc;
    logic [OW-1:0]  r_rsp_data;
    logic [NW-1:0]  r_n;
    logic [NW-1:0]  r_cnt;
    logic [NW-1:0]  r_m;
    logic [2:0]     r_op;
    logic           r_err;
    logic           r_rsp_valid;
    logic           r_busy;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic [2:0]      w_op;
    logic [NW-1:0]   w_n;
    logic            w_hs;
    logic [NW-1:0]   w_opnd;
    logic [OW-1:0]   w_prod;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Operand fields of the granted requester
    always_comb begin
        w_op = '0;
        w_n  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_idx == IDW'(i)) begin
                w_op = req_opcode[3*i +: 3];
                w_n  = req_n[NW*i +: NW];
            end
        end
    end

    assign w_hs      = (r_state == IDLE) && !reset && (|w_grant);
    assign req_ready = w_hs ? w_grant : '0;

    // Factorial walks the down-counter; square/cube reuse the latched operand
    assign w_opnd = (r_op == OP_FACT) ? r_cnt : r_n;
    assign w_prod = r_acc * OW'(w_opnd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_acc       <= '0;
            r_rsp_data  <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_m         <= '0;
            r_op        <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_ptr  <= w_idx;
                        r_id   <= w_idx;
                        r_op   <= w_op;
                        r_n    <= w_n;
                        r_cnt  <= w_n;
                        r_busy <= 1'b1;
                        case (w_op)
                            OP_SQUARE, OP_CUBE: begin
                                r_acc   <= OW'(w_n);
                                r_m     <= (w_op == OP_CUBE) ? NW'(2) : NW'(1);
                                r_state <= CALC;
                            end
                            OP_FACT: begin
                                r_acc <= OW'(1);
                                if (w_n >= NW'(2)) begin
                                    r_m     <= w_n - NW'(1);
                                    r_state <= CALC;
                                end else begin
                                    r_m         <= '0;
                                    r_rsp_data  <= OW'(1);
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= RESP;
                                end
                            end
                            default: begin
                                r_acc       <= '0;
                                r_m         <= '0;
                                r_err       <= 1'b1;
                                r_rsp_data  <= '0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= RESP;
                            end
                        endcase
                    end
                end
                CALC: begin
                    r_acc <= w_prod;
                    r_m   <= r_m - NW'(1);
                    r_cnt <= r_cnt - NW'(1);
                    if (r_m == NW'(1)) begin
                        r_rsp_data  <= w_prod;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_id;
    assign rsp_err   = r_err;
    assign busy      = r_busy;

endmodule
